datapath_controller: RTL

Control sequencer that sits in front of the 8-bit datapath (register file plus ALU).
- Accepts 16-bit instruction words over a valid/ready handshake and decodes each one.
- Drives the datapath control inputs: writeEnable, muxSel, inputData, dstSel, A_sel, B_sel, OP_Sel.
- Sequences every write so the datapath's gated write clock (clk AND writeEnable) sees exactly one clean rising edge per instruction.

---
 rtl/datapath_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - instruction sequencer driving the 8-bit register-file/ALU datapath
// Optional build macro: CTRL_SINGLE_STEP_EN (adds stepMode/step single-step gating of acceptance)
module datapath_controller #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             stepMode,
  input  logic             step,
`endif
  input  logic             instrValid,
  input  logic [15:0]      instr,
  output logic             instrReady,
  output logic             writeEnable,
  output logic             muxSel,
  output logic [7:0]       inputData,
  output logic [3:0]       dstSel,
  output logic [3:0]       A_sel,
  output logic [3:0]       B_sel,
  output logic [3:0]       OP_Sel,
  output logic             halted,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_RETIRE, S_HALTED} state_t;

  localparam logic [3:0] OP_NOP   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_LOADI = 4'hF;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == 4'h0) || ((op >= 4'h4) && (op <= 4'h9));
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_alu(op) || (op == OP_LOADI) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic             arm_q, arm_d;
  logic             accept;
  logic             step_ok;

  logic       we_q, we_d;
  logic       mux_q, mux_d;
  logic [7:0] data_q, data_d;
  logic [3:0] dst_q, dst_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] op_q, op_d;

  // Next-state and bookkeeping for the posedge FSM (handshake, counter, sticky flags)
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    arm_d     = arm_q;
    accept    = ready_q && instrValid;
`ifdef CTRL_SINGLE_STEP_EN
    // A single armed bit: extra pulses before acceptance collapse into one
    if (step && (state_q != S_HALTED)) arm_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          instr_d   = instr;
          state_d   = S_SETUP;
          illegal_d = illegal_q | ~is_legal(instr[15:12]);
          arm_d     = 1'b0;
        end
      end
      S_SETUP:  state_d = (is_alu(instr_q[15:12]) || (instr_q[15:12] == OP_LOADI)) ? S_WRITE : S_RETIRE;
      S_WRITE:  state_d = S_RETIRE;
      S_RETIRE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (instr_q[15:12] == OP_HALT) ? S_HALTED : S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
`ifdef CTRL_SINGLE_STEP_EN
    step_ok = !stepMode || arm_d;
`else
    step_ok = 1'b1;
`endif
    ready_d  = (state_d == S_IDLE) && step_ok;
    halted_d = (state_d == S_HALTED);
  end

  // FSM state, latched instruction, retire counter and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      arm_q     <= arm_d;
    end
  end

  // Datapath controls: selects load in SETUP and hold; write enable only in WRITE
  always_comb begin
    we_d   = 1'b0;
    mux_d  = mux_q;
    data_d = data_q;
    dst_d  = dst_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    case (state_q)
      S_SETUP: begin
        dst_d = instr_q[11:8];
        a_d   = instr_q[7:4];
        b_d   = instr_q[3:0];
        mux_d = (instr_q[15:12] == OP_LOADI);
        if (instr_q[15:12] == OP_LOADI) data_d = instr_q[7:0];
        if (is_alu(instr_q[15:12]))     op_d   = instr_q[15:12];
      end
      S_WRITE: we_d = 1'b1;
      default: ;
    endcase
  end

  // Registered on negedge so writeEnable moves only while clk is low (clean gated write clock)
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      mux_q  <= 1'b0;
      data_q <= '0;
      dst_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
    end else begin
      we_q   <= we_d;
      mux_q  <= mux_d;
      data_q <= data_d;
      dst_q  <= dst_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
    end
  end

  assign instrReady  = ready_q;
  assign writeEnable = we_q;
  assign muxSel      = mux_q;
  assign inputData   = data_q;
  assign dstSel      = dst_q;
  assign A_sel       = a_q;
  assign B_sel       = b_q;
  assign OP_Sel      = op_q;
  assign halted      = halted_q;
  assign illegalOp   = illegal_q;
  assign instrCount  = cnt_q;

endmodule
